part_2_trgt_upload_buf: RTL
===========================

// Module: part_2_trgt_upload_buf
// PURPOSE
//  Target-side upload stage between the SUT output pins and the fringe put/transport engine.
//  - Samples the SUT result vector {valid,o_data} on a sample request.
//  - Tags each sample with an event number and sequence count, and buffers it in a FIFO.
//  - Hands entries to the put engine over a valid/ready handshake.
//  - Raises a freeze request when nearly full, so mission clocks stall instead of losing data.
// PARAMETERS
//  DEPTH          8    FIFO entries; power of 2, >=2
//  EVENT_NO       3    event index stamped on every entry (2 bits)
//  FREEZE_MARGIN  1    freeze_o asserts when count >= DEPTH-FREEZE_MARGIN; 1..DEPTH-1
//  WDOG_MAX       100  consecutive stalled cycles before timeout_o sets; >=1
// PORTS
//  clk_i         in   1   utility clock; all logic on posedge
//  rst_i         in   1   asynchronous active-high reset
//  sample_req_i  in   1   1-cycle pulse: capture SUT outputs this cycle
//  sut_valid_i   in   1   SUT valid output
//  sut_data_i    in   8   SUT o_data output
//  put_valid_o   out  1   head entry available
//  put_ready_i   in   1   put engine accepts head entry
//  put_event_o   out  2   head entry event number
//  put_seq_o     out  8   head entry sequence number
//  put_data_o    out  9   head entry payload {valid,o_data}
//  count_o       out  $clog2(DEPTH)+1  current occupancy
//  freeze_o      out  1   request to block the mission clock (drives freeze_clk[EVENT_NO])
//  overflow_o    out  1   sticky: a sample was dropped
//  timeout_o     out  1   sticky: head stalled WDOG_MAX cycles
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, seq=0, watchdog=0. Reset mid-operation discards all entries.
//  Push:
//  - push = sample_req_i && (!full || pop).
//  - Stores {EVENT_NO, seq, sut_valid_i, sut_data_i}; seq increments mod 256.
//  Drop:
//  - sample_req_i && full && !pop drops the sample.
//  - The drop sets overflow_o (cleared only by reset); seq does not increment.
//  Read side:
//  - First-word-fall-through: put_valid_o = !empty; put_* show the head entry.
//  - Outputs are held stable while put_valid_o && !put_ready_i.
//  - pop = put_valid_o && put_ready_i. put_ready_i while empty is ignored.
//  Latency:
//  - A sample at edge N on an empty FIFO gives put_valid_o=1 after edge N (visible in cycle N+1).
//  - There is no same-cycle bypass.
//  Simultaneous push+pop:
//  - Both occur; count unchanged.
//  - Legal when full, because the freed slot is reused.
//  Pointers: $clog2(DEPTH) bits, wrap naturally; count_o = registered occupancy 0..DEPTH.
//  freeze_o:
//  - freeze_o = (count_o >= DEPTH-FREEZE_MARGIN), decoded from the registered count.
//  - Deasserts in the cycle after the pop that takes count below the threshold.
//  Watchdog:
//  - Counter increments each cycle with put_valid_o && !put_ready_i.
//  - Clears on pop or when empty.
//  - At WDOG_MAX it sets timeout_o (sticky) and saturates.
//  Stall FSM (2 states):
//  - IDLE -> STALL when put_valid_o && !put_ready_i.
//  - STALL -> IDLE on pop or empty.
//  - The watchdog counts only in STALL.
// STRUCTURE
//  Package cs_upload_pkg:
//  - typedef upload_entry_t {logic [1:0] event_no; logic [7:0] seq; logic [8:0] payload;}
//  - typedef enum {UPL_IDLE, UPL_STALL}
//  - localparam UPL_PAYLOAD_W = 9
//  Sub-module cs_sync_fifo:
//  - Parameterized by type and DEPTH; FWFT; push/pop/full/empty/count.
//  - Holds storage and pointers.
//  Top level: sequence counter, drop/overflow logic, freeze decode, stall FSM and watchdog.
// TESTING
//  1) Reset, then one sample_req_i with valid=1, data=0xA5, ready=0 ->
//     next cycle put_valid_o=1, put_data_o=0x1A5, put_seq_o=0, put_event_o=3.
//  2) 8 samples (data 0x00..0x07), ready=0 -> count_o=8, freeze_o first at count 7;
//     9th sample -> overflow_o=1, count stays 8; drain with ready=1 -> seq 0..7 and data 0x00..0x07, in order.
//  3) Full FIFO, sample_req_i and put_ready_i in the same cycle -> count stays 8, overflow_o=0,
//     new entry seq=8 at the tail.
//  4) Single entry, ready=0 for 100 cycles -> timeout_o=1 on cycle 100 and stays set;
//     a pop then clears the watchdog, but not timeout_o.
//  5) 300 samples with ready=1 -> put_seq_o wraps 255->0; no drops; count_o never exceeds 1.
//  6) rst_i pulsed asynchronously with 5 entries buffered -> immediately put_valid_o=0, count_o=0,
//     flags 0; next sample gets seq=0.

Source files
------------

// File: rtl/cs_upload_pkg.sv
// Shared types for the target-side upload buffer.
package cs_upload_pkg;

  localparam int unsigned UPL_PAYLOAD_W = 9;

  // One buffered sample: event stamp, sequence count and {valid,o_data}.
  typedef struct packed {
    logic [1:0]               event_no;
    logic [7:0]               seq;
    logic [UPL_PAYLOAD_W-1:0] payload;
  } upload_entry_t;

  typedef enum logic {
    UPL_IDLE,
    UPL_STALL
  } upl_state_e;

endpackage

// File: rtl/cs_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy count.
module cs_sync_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  T              wdata_i,
  input  logic          pop_i,
  output T              rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/part_2_trgt_upload_buf.sv
// Upload buffer between SUT output pins and the put engine: stamps samples,
// buffers them, requests a mission-clock freeze when nearly full and watches
// for a stalled head entry.
module part_2_trgt_upload_buf
  import cs_upload_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned EVENT_NO      = 3,
  parameter int unsigned FREEZE_MARGIN = 1,
  parameter int unsigned WDOG_MAX      = 100,
  localparam int unsigned CW           = $clog2(DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_req_i,
  input  logic                     sut_valid_i,
  input  logic [7:0]               sut_data_i,
  output logic                     put_valid_o,
  input  logic                     put_ready_i,
  output logic [1:0]               put_event_o,
  output logic [7:0]               put_seq_o,
  output logic [UPL_PAYLOAD_W-1:0] put_data_o,
  output logic [CW-1:0]            count_o,
  output logic                     freeze_o,
  output logic                     overflow_o,
  output logic                     timeout_o
);

  localparam int unsigned WW = $clog2(WDOG_MAX + 1);

  upload_entry_t wr_entry;
  upload_entry_t head;
  upload_entry_t head_vis;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          drop;
  logic          stall;
  logic [7:0]    seq_q;
  logic          overflow_q;
  logic          timeout_q;
  logic [WW-1:0] wdog_q;
  logic          wdog_run;
  upl_state_e    state_q;
  upl_state_e    state_d;

  assign pop   = !fifo_empty && put_ready_i;
  assign push  = sample_req_i && (!fifo_full || pop);
  assign drop  = sample_req_i && fifo_full && !pop;
  assign stall = !fifo_empty && !put_ready_i;

  assign wr_entry = '{event_no: 2'(EVENT_NO),
                      seq:      seq_q,
                      payload:  {sut_valid_i, sut_data_i}};

  cs_sync_fifo #(
    .T     (upload_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  always_comb begin
    head_vis = '0;
    if (!fifo_empty) begin
      head_vis = head;
    end
  end

  assign put_valid_o = !fifo_empty;
  assign put_event_o = head_vis.event_no;
  assign put_seq_o   = head_vis.seq;
  assign put_data_o  = head_vis.payload;
  assign count_o     = fifo_count;
  assign freeze_o    = (fifo_count >= CW'(DEPTH - FREEZE_MARGIN));
  assign overflow_o  = overflow_q;
  assign timeout_o   = timeout_q;

  // Sequence count advances only on accepted samples; drops are sticky.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        seq_q <= seq_q + 8'd1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Stall FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= UPL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UPL_IDLE:  if (stall) state_d = UPL_STALL;
      UPL_STALL: if (pop || fifo_empty) state_d = UPL_IDLE;
      default:   state_d = UPL_IDLE;
    endcase
  end

  // Watchdog runs for every cycle the FSM spends in (or enters) STALL, so the
  // first stalled cycle is counted and timeout lands on stalled cycle WDOG_MAX.
  always_comb begin
    wdog_run = (state_d == UPL_STALL);
  end

  // Saturating watchdog with sticky timeout flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else if (!wdog_run) begin
      wdog_q <= '0;
    end else if (wdog_q != WW'(WDOG_MAX)) begin
      wdog_q <= wdog_q + WW'(1);
      if (wdog_q == WW'(WDOG_MAX - 1)) begin
        timeout_q <= 1'b1;
      end
    end
  end

endmodule
